// File: rtl/axis_frame_src.sv
// AXI-Stream test-frame generator: emits runs of fixed-length frames with a
// selectable data pattern, inter-frame gaps, graceful stop and error injection.
module axis_frame_src #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_frames,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic              cfg_err_en,
  input  logic [LEN_W-1:0]  cfg_err_beat,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  frames_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              user;
  } beat_t;

  state_t            state;
  logic [LEN_W-1:0]  beat;
  logic [GAP_W-1:0]  gap_cnt;
  logic              stop_pend;
  logic [LEN_W-1:0]  lat_len;
  logic [CNT_W-1:0]  lat_frames;
  logic [GAP_W-1:0]  lat_gap;
  logic [1:0]        lat_mode;
  logic [DATA_W-1:0] lat_seed;
  logic              lat_err_en;
  logic [LEN_W-1:0]  lat_err_beat;

  // Beat k of a frame; beats at or past len never compare equal to k, so an
  // out-of-range error beat injects nothing.
  function automatic beat_t gen_beat(
    input logic [LEN_W-1:0]  k,
    input logic [LEN_W-1:0]  len,
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] seed,
    input logic              err_en,
    input logic [LEN_W-1:0]  err_beat
  );
    beat_t             b;
    logic [DATA_W-1:0] kx;
    kx = DATA_W'(k);
    case (mode)
      2'd0:    b.data = seed + kx;
      2'd1:    b.data = seed - kx;
      2'd2:    b.data = seed;
      default: b.data = DATA_W'(1) << (32'(k) % 32'(DATA_W));
    endcase
    b.user = err_en && (k == err_beat);
    if (b.user) b.data = ~b.data;
    b.last = (k == len - LEN_W'(1));
    return b;
  endfunction

  logic  hs, stop_now, last_frame;
  beat_t run_first, frame_first, nxt_beat;

  always_comb begin
    hs          = m_axis_tvalid & m_axis_tready;
    stop_now    = stop_pend | stop;
    last_frame  = (lat_frames != '0) && (frames_sent + CNT_W'(1) == lat_frames);
    run_first   = gen_beat('0, cfg_len, cfg_mode, cfg_seed, cfg_err_en, cfg_err_beat);
    frame_first = gen_beat('0, lat_len, lat_mode, lat_seed, lat_err_en, lat_err_beat);
    nxt_beat    = gen_beat(beat + LEN_W'(1), lat_len, lat_mode, lat_seed, lat_err_en,
                           lat_err_beat);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      beat          <= '0;
      gap_cnt       <= '0;
      stop_pend     <= 1'b0;
      lat_len       <= '0;
      lat_frames    <= '0;
      lat_gap       <= '0;
      lat_mode      <= '0;
      lat_seed      <= '0;
      lat_err_en    <= 1'b0;
      lat_err_beat  <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frames_sent   <= '0;
    end else begin
      done <= 1'b0;
      if (busy && stop) stop_pend <= 1'b1;
      case (state)
        IDLE: if (start && cfg_len != '0) begin
          lat_len       <= cfg_len;
          lat_frames    <= cfg_frames;
          lat_gap       <= cfg_gap;
          lat_mode      <= cfg_mode;
          lat_seed      <= cfg_seed;
          lat_err_en    <= cfg_err_en;
          lat_err_beat  <= cfg_err_beat;
          frames_sent   <= '0;
          stop_pend     <= 1'b0;
          beat          <= '0;
          busy          <= 1'b1;
          state         <= SEND;
          m_axis_tvalid <= 1'b1;
          {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= run_first;
        end
        SEND: if (hs) begin
          if (!m_axis_tlast) begin
            beat <= beat + LEN_W'(1);
            {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= nxt_beat;
          end else begin
            if (frames_sent != '1) frames_sent <= frames_sent + CNT_W'(1);
            if (last_frame || stop_now) begin
              state         <= FIN;
              done          <= 1'b1;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tuser  <= 1'b0;
            end else if (lat_gap != '0) begin
              state         <= GAP;
              gap_cnt       <= lat_gap - GAP_W'(1);
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tuser  <= 1'b0;
            end else begin
              beat <= '0;
              {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= frame_first;
            end
          end
        end
        GAP: begin
          if (stop_now) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (gap_cnt == '0) begin
            state         <= SEND;
            beat          <= '0;
            m_axis_tvalid <= 1'b1;
            {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= frame_first;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        FIN: begin
          state     <= IDLE;
          busy      <= 1'b0;
          stop_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_frame_src.md
AXIS_FRAME_SRC -- requirements
Module: axis_frame_src

Interface
REQ-001 SHALL have parameter DATA_W, default 32: tdata width, min 8.
REQ-002 SHALL have parameter LEN_W, default 16: width of frame-length and beat-index fields.
REQ-003 SHALL have parameter CNT_W, default 16: width of frame-count fields.
REQ-004 SHALL have parameter GAP_W, default 8: width of the inter-frame gap field.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, named as the codebase does: aclk first, then aresetn.
REQ-006 aclk  in  1  clock; all logic is rising-edge.
REQ-007 aresetn  in  1  async active-low reset.
REQ-008 start  in  1  one-cycle run request, sampled only in IDLE.
REQ-009 stop  in  1  graceful stop request, sampled any cycle while busy.
REQ-010 cfg_len  in  LEN_W  beats per frame.
REQ-011 cfg_frames  in  CNT_W  frames per run; 0 = continuous until stop.
REQ-012 cfg_gap  in  GAP_W  idle cycles between frames.
REQ-013 cfg_mode  in  2  pattern: 0 incrementing, 1 decrementing, 2 constant, 3 walking-one.
REQ-014 cfg_seed  in  DATA_W  pattern seed.
REQ-015 cfg_err_en  in  1  enables error injection.
REQ-016 cfg_err_beat  in  LEN_W  beat index (0-based) to corrupt in every frame.
REQ-017 m_axis_tdata  out  DATA_W  stream data.
REQ-018 m_axis_tvalid  out  1  stream valid.
REQ-019 m_axis_tready  in  1  stream ready.
REQ-020 m_axis_tlast  out  1  last beat of frame.
REQ-021 m_axis_tuser  out  1  marks an injected-error beat.
REQ-022 busy  out  1  high from the cycle after an accepted start until done.
REQ-023 done  out  1  one-cycle pulse at end of run.
REQ-024 frames_sent  out  CNT_W  completed frames in current or last run.

Function
REQ-025 SHALL implement FSM IDLE, SEND, GAP, FIN; start accepted only in IDLE with cfg_len != 0, else ignored.
REQ-026 On accepted start all cfg_* SHALL be latched; later cfg_* changes have no effect until the next run; frames_sent cleared to 0.
REQ-027 Transitions: IDLE->SEND on accepted start; SEND->GAP on tlast handshake when more frames remain and cfg_gap != 0; SEND->SEND (new frame) when more remain and cfg_gap == 0; SEND->FIN on last-frame tlast handshake; GAP->SEND after exactly cfg_gap cycles; FIN->IDLE after one cycle with done=1.
REQ-028 First tvalid SHALL assert in the cycle after start is sampled (latency 1).
REQ-029 Once tvalid=1, tdata/tlast/tuser SHALL stay stable until tvalid&tready; tvalid SHALL not deassert without a handshake.
REQ-030 Beat counter SHALL advance only on handshake; tlast=1 exactly on beat cfg_len-1.
REQ-031 Pattern per beat k of each frame (mod 2^DATA_W): mode0 seed+k; mode1 seed-k; mode2 seed; mode3 1<<(k mod DATA_W).
REQ-032 When cfg_err_en=1 and k==cfg_err_beat, tdata SHALL be the bitwise inverse of the pattern and tuser=1; tuser=0 on all other beats; cfg_err_beat >= cfg_len injects nothing.
REQ-033 frames_sent SHALL increment on each tlast handshake and saturate at all-ones.
REQ-034 stop SHALL be registered as pending; the current frame completes; pending stop in GAP or at tlast handshake SHALL go to FIN; no partial frames.
REQ-035 stop and start in the same IDLE cycle: start wins, stop ignored.
REQ-036 cfg_len=1: every beat carries tlast=1.
REQ-037 tvalid SHALL be 0 in IDLE, GAP and FIN.

Reset
REQ-038 aresetn low SHALL force IDLE immediately, mid-frame included; tvalid, tlast, tuser, busy, done = 0; tdata = 0; frames_sent = 0; stop-pending cleared.
REQ-039 After aresetn rises, no output activity until a new start.

Verification
REQ-040 len=4, frames=2, gap=3, mode0, seed=0x10, tready=1 -> 0x10..0x13 tlast on 0x13, 3 idle cycles, repeat, done pulse, frames_sent=2.
REQ-041 len=3, mode3, tready toggling 1/0 -> data 0x1,0x2,0x4 each held stable while tready=0, no beat lost.
REQ-042 len=4, mode2 seed=0xA5A5A5A5, err_en, err_beat=2 -> beat 2 = 0x5A5A5A5A with tuser=1, others tuser=0.
REQ-043 frames=0, len=5, stop asserted mid beat 2 of frame 3 -> frame 3 completes, frames_sent=3, done pulse.
REQ-044 aresetn low during beat 1 -> tvalid=0, busy=0 immediately; subsequent start with cfg_len=0 ignored, busy stays 0.
